// File: rtl/npc_pc_pkg.sv
// rtl/npc_pc_pkg.sv - shared CPU definitions for next-PC selection
package npc_pc_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6,
    BR_RSV  = 3'd7
  } br_type_e;

  typedef enum logic [1:0] {
    J_NONE = 2'd0,
    J_J    = 2'd1,
    J_JR   = 2'd2,
    J_RSV  = 2'd3
  } j_type_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;
  localparam logic [31:0] ADDR_LO      = 32'h0000_3000;
  localparam logic [31:0] ADDR_HI      = 32'h0000_4ffc;

  // Reserved encoding 7 decodes as "no branch"
  function automatic logic is_branch(input logic [2:0] t);
    return (t != BR_NONE) && (t != BR_RSV);
  endfunction

endpackage

// File: rtl/npc_pc_br_cond.sv
// rtl/npc_pc_br_cond.sv - branch condition and jump decode for the ID instruction
module br_cond
  import npc_pc_pkg::*;
(
  input  logic [2:0] br_type,
  input  logic [1:0] j_type,
  input  logic       beq,
  input  logic       greater0,
  input  logic       less0,
  input  logic       equal0,
  output logic       br_hit,
  output logic       jmp
);

  always_comb begin
    br_hit = 1'b0;
    case (br_type)
      BR_BEQ:  br_hit = beq;
      BR_BNE:  br_hit = ~beq;
      BR_BLEZ: br_hit = less0 | equal0;
      BR_BGTZ: br_hit = greater0;
      BR_BLTZ: br_hit = less0;
      BR_BGEZ: br_hit = ~less0;
      default: br_hit = 1'b0;
    endcase
  end

  assign jmp = (j_type == J_J) || (j_type == J_JR);

endmodule

// File: rtl/npc_pc.sv
// rtl/npc_pc.sv - fetch PC register and next-PC mux; NPC_BRANCH_STATS_EN adds branch counters
module npc_pc
  import npc_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  br_type,
  input  logic        beq,
  input  logic        greater0,
  input  logic        less0,
  input  logic        equal0,
  input  logic [1:0]  j_type,
  input  logic [25:0] instr_index,
  input  logic [31:0] jr_target,
  input  logic [15:0] imm16,
  input  logic [31:0] pc4_id,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        taken,
  output logic        bd,
`ifdef NPC_BRANCH_STATS_EN
  output logic        adel,
  output logic [31:0] br_cnt,
  output logic [31:0] br_taken_cnt
`else
  output logic        adel
`endif
);

  logic        br_hit;
  logic        jmp;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] redirect;
  logic [31:0] next_pc;

  br_cond u_br_cond (
    .br_type  (br_type),
    .j_type   (j_type),
    .beq      (beq),
    .greater0 (greater0),
    .less0    (less0),
    .equal0   (equal0),
    .br_hit   (br_hit),
    .jmp      (jmp)
  );

  assign taken     = (br_hit | jmp) & ~stall;
  assign br_target = pc4_id + {{14{imm16[15]}}, imm16, 2'b00};
  assign j_target  = {pc4_id[31:28], instr_index, 2'b00};

  // A jump overrides any branch encoding that happens to share the cycle
  always_comb begin
    redirect = br_target;
    if (j_type == J_J)
      redirect = j_target;
    else if (j_type == J_JR)
      redirect = jr_target;
  end

  always_comb begin
    next_pc = pc4;
    if (exc_req)
      next_pc = EXC_VEC;
    else if (eret_req)
      next_pc = epc;
    else if (stall)
      next_pc = pc;
    else if (taken)
      next_pc = redirect;
  end

  assign pc4  = pc + 32'd4;
  assign adel = (pc[1:0] != 2'b00) || (pc < ADDR_LO) || (pc > ADDR_HI);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
      bd <= 1'b0;
    end else begin
      pc <= next_pc;
      if (exc_req || eret_req)
        bd <= 1'b0;
      else if (!stall)
        bd <= is_branch(br_type) | jmp;
    end
  end

`ifdef NPC_BRANCH_STATS_EN
  logic br_count_en;

  assign br_count_en = ~stall & ~exc_req & is_branch(br_type);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_cnt       <= 32'd0;
      br_taken_cnt <= 32'd0;
    end else if (br_count_en) begin
      br_cnt <= br_cnt + 32'd1;
      if (br_hit)
        br_taken_cnt <= br_taken_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_npc_pc.sv
// tb/tb_npc_pc.sv - scoreboard bench for npc_pc
`timescale 1ns/1ps
module tb_npc_pc;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [2:0]  br_type;
  logic        beq;
  logic        greater0;
  logic        less0;
  logic        equal0;
  logic [1:0]  j_type;
  logic [25:0] instr_index;
  logic [31:0] jr_target;
  logic [15:0] imm16;
  logic [31:0] pc4_id;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        taken;
  logic        bd;
  logic        adel;
`ifdef NPC_BRANCH_STATS_EN
  logic [31:0] br_cnt;
  logic [31:0] br_taken_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic        bd;
    logic        adel;
  } exp_t;

  exp_t sb[$];

  npc_pc dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .br_type     (br_type),
    .beq         (beq),
    .greater0    (greater0),
    .less0       (less0),
    .equal0      (equal0),
    .j_type      (j_type),
    .instr_index (instr_index),
    .jr_target   (jr_target),
    .imm16       (imm16),
    .pc4_id      (pc4_id),
    .exc_req     (exc_req),
    .eret_req    (eret_req),
    .epc         (epc),
    .pc          (pc),
    .pc4         (pc4),
    .taken       (taken),
    .bd          (bd),
`ifdef NPC_BRANCH_STATS_EN
    .adel        (adel),
    .br_cnt      (br_cnt),
    .br_taken_cnt(br_taken_cnt)
`else
    .adel        (adel)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at time limit, required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stall       = 1'b0;
    br_type     = 3'd0;
    beq         = 1'b0;
    greater0    = 1'b0;
    less0       = 1'b0;
    equal0      = 1'b0;
    j_type      = 2'd0;
    instr_index = 26'd0;
    jr_target   = 32'd0;
    imm16       = 16'd0;
    pc4_id      = 32'd0;
    exc_req     = 1'b0;
    eret_req    = 1'b0;
    epc         = 32'd0;
  endtask

  task automatic chk_taken(input string tag, input logic exp);
    #1;
    chk(tag, {31'd0, taken}, {31'd0, exp});
  endtask

  // Expected post-edge state is queued with the stimulus, then retired after the edge
  task automatic tick(input logic [31:0] p, input logic b, input logic a);
    exp_t e;
    e.pc   = p;
    e.bd   = b;
    e.adel = a;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("pc", pc, e.pc);
    chk("pc4", pc4, e.pc + 32'd4);
    chk("bd", {31'd0, bd}, {31'd0, e.bd});
    chk("adel", {31'd0, adel}, {31'd0, e.adel});
  endtask

  task automatic jr_to(input logic [31:0] t);
    idle();
    j_type    = 2'd2;
    jr_target = t;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #2 reset = 1'b0;
    #1;
    chk("rst_async_pc", pc, 32'h0000_3000);
    chk("rst_async_bd", {31'd0, bd}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_rel_pc", pc, 32'h0000_3000);
    chk("rst_rel_taken", {31'd0, taken}, 32'd0);
    chk("rst_rel_adel", {31'd0, adel}, 32'd0);
    tick(32'h0000_3004, 1'b0, 1'b0);
    tick(32'h0000_3008, 1'b0, 1'b0);

    idle(); br_type = 3'd1; beq = 1'b1; pc4_id = 32'h0000_3010; imm16 = 16'hfffe;
    chk_taken("beq_taken", 1'b1);
    tick(32'h0000_3008, 1'b1, 1'b0);
    idle();
    tick(32'h0000_300c, 1'b0, 1'b0);

    idle(); br_type = 3'd6; less0 = 1'b1; pc4_id = 32'h0000_3010; imm16 = 16'h0010;
    chk_taken("bgez_nt", 1'b0);
    tick(32'h0000_3010, 1'b1, 1'b0);
    idle();
    tick(32'h0000_3014, 1'b0, 1'b0);

    idle(); br_type = 3'd2; pc4_id = 32'h0000_3100; imm16 = 16'h0004;
    chk_taken("bne_taken", 1'b1);
    tick(32'h0000_3110, 1'b1, 1'b0);

    idle(); br_type = 3'd3; equal0 = 1'b1; pc4_id = 32'h0000_3200; imm16 = 16'h0001;
    chk_taken("blez_eq", 1'b1);
    tick(32'h0000_3204, 1'b1, 1'b0);

    idle(); br_type = 3'd3; greater0 = 1'b1; pc4_id = 32'h0000_3300; imm16 = 16'h0040;
    chk_taken("blez_nt", 1'b0);
    tick(32'h0000_3208, 1'b1, 1'b0);

    idle(); br_type = 3'd4; greater0 = 1'b1; pc4_id = 32'h0000_3300;
    chk_taken("bgtz_taken", 1'b1);
    tick(32'h0000_3300, 1'b1, 1'b0);

    idle(); br_type = 3'd5; less0 = 1'b1; pc4_id = 32'h0000_3400; imm16 = 16'hffff;
    chk_taken("bltz_taken", 1'b1);
    tick(32'h0000_33fc, 1'b1, 1'b0);

    idle(); br_type = 3'd7; beq = 1'b1; pc4_id = 32'h0000_3800; imm16 = 16'h0010;
    chk_taken("rsv_nt", 1'b0);
    tick(32'h0000_3400, 1'b0, 1'b0);

    idle(); j_type = 2'd1; pc4_id = 32'h0000_3404; instr_index = 26'h0000c80;
    chk_taken("j_taken", 1'b1);
    tick(32'h0000_3200, 1'b1, 1'b0);

    jr_to(32'h0000_3400); stall = 1'b1;
    chk_taken("jr_stall_mask", 1'b0);
    tick(32'h0000_3200, 1'b1, 1'b0);
    tick(32'h0000_3200, 1'b1, 1'b0);
    stall = 1'b0;
    chk_taken("jr_unstall", 1'b1);
    tick(32'h0000_3400, 1'b1, 1'b0);

    jr_to(32'h0000_3500); stall = 1'b1; exc_req = 1'b1; eret_req = 1'b1; epc = 32'h0000_3020;
    tick(32'h0000_4180, 1'b0, 1'b0);
    idle(); eret_req = 1'b1; epc = 32'h0000_3020;
    tick(32'h0000_3020, 1'b0, 1'b0);

    jr_to(32'h0000_3002);
    tick(32'h0000_3002, 1'b1, 1'b1);
    idle();
    tick(32'h0000_3006, 1'b0, 1'b1);
    jr_to(32'h0000_5000);
    tick(32'h0000_5000, 1'b1, 1'b1);
    jr_to(32'h0000_4ffc);
    tick(32'h0000_4ffc, 1'b1, 1'b0);
    idle();
    tick(32'h0000_5000, 1'b0, 1'b1);
    jr_to(32'h0000_2ffc);
    tick(32'h0000_2ffc, 1'b1, 1'b1);
    jr_to(32'hffff_fffc);
    tick(32'hffff_fffc, 1'b1, 1'b1);
    idle();
    tick(32'h0000_0000, 1'b0, 1'b1);
    jr_to(32'h0000_3000);
    tick(32'h0000_3000, 1'b1, 1'b0);

    idle(); stall = 1'b1; eret_req = 1'b1; epc = 32'h0000_3100;
    tick(32'h0000_3100, 1'b0, 1'b0);

`ifdef NPC_BRANCH_STATS_EN
    chk("br_cnt", br_cnt, 32'd7);
    chk("br_taken_cnt", br_taken_cnt, 32'd5);
`endif

    jr_to(32'h0000_3800);
    tick(32'h0000_3800, 1'b1, 1'b0);
    jr_to(32'h0000_3400);
    #1 reset = 1'b0;
    #1;
    chk("rst_mid_pc", pc, 32'h0000_3000);
    chk("rst_mid_bd", {31'd0, bd}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_pc", pc, 32'h0000_3000);
    idle();
    reset = 1'b1;
    tick(32'h0000_3004, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
